// File: rtl/pool_max2x2_if.sv
// Pixel stream bundle for pool_max2x2: input beats from accum, pooled output pulses.
// master drives the input stream and observes results; slave is the pooling stage.
interface pool_max2x2_if #(
    parameter int DWIDTH = 16
);
    logic                     in_valid;
    logic signed [DWIDTH-1:0] pixel_in;
    logic                     out_valid;
    logic signed [DWIDTH-1:0] pixel_out;
    logic                     frame_done;

    modport master (
        output in_valid, pixel_in,
        input  out_valid, pixel_out, frame_done
    );

    modport slave (
        input  in_valid, pixel_in,
        output out_valid, pixel_out, frame_done
    );
endinterface

// File: rtl/pool_max2x2.sv
// Streaming 2x2/stride-2 signed max pooling over one row-major feature map; RENKON_POOL_RELU_EN clamps output at 0.
// Latency: pooled pixel is registered 1 cycle after the odd-row/odd-col input beat.
// Backpressure: none; accepts 1 pixel per cycle, gaps in in_valid are legal.
module pool_max2x2 #(
    parameter int DWIDTH   = 16,
    parameter int MAXWIDTH = 32,
    parameter int SWIDTH   = $clog2(MAXWIDTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SWIDTH-1:0] fm_width,
    input  logic [SWIDTH-1:0] fm_height,
    output logic              busy,
    pool_max2x2_if.slave      pix
);

    localparam int                LB_DEPTH = MAXWIDTH / 2;
    localparam int                LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [SWIDTH-1:0] MAXW     = SWIDTH'(MAXWIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                   state_q, state_d;
    logic [SWIDTH-1:0]        width_q, height_q;
    logic [SWIDTH-1:0]        col_q, row_q;
    logic signed [DWIDTH-1:0] h_q;
    logic signed [DWIDTH-1:0] linebuf [LB_DEPTH];
    logic                     out_valid_q, frame_done_q;
    logic signed [DWIDTH-1:0] pixel_out_q;

    logic                     sizes_ok;
    logic                     col_last, row_last;
    logic                     accept, cnt_clr, last_beat;
    logic [LBW-1:0]           lb_idx;
    logic signed [DWIDTH-1:0] px, lb_val, pair_max, win_max, win_out;

    assign px       = pix.pixel_in;
    assign sizes_ok = !fm_width[0]  && (fm_width != '0) && (fm_width <= MAXW) &&
                      !fm_height[0] && (fm_height != '0);
    assign col_last = (col_q == width_q - 1'b1);
    assign row_last = (row_q == height_q - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A start always clears the counters; illegal sizes leave (or drop back to) IDLE.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        cnt_clr   = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    if (sizes_ok) state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    state_d = sizes_ok ? ACTIVE : IDLE;
                end else if (pix.in_valid) begin
                    accept = 1'b1;
                    if (col_last && row_last) begin
                        last_beat = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            width_q  <= '0;
            height_q <= '0;
        end else if (start && sizes_ok) begin
            width_q  <= fm_width;
            height_q <= fm_height;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign lb_idx   = col_q[LBW:1];
    assign lb_val   = linebuf[lb_idx];
    assign pair_max = (px > h_q) ? px : h_q;
    assign win_max  = (pair_max > lb_val) ? pair_max : lb_val;
`ifdef RENKON_POOL_RELU_EN
    assign win_out  = win_max[DWIDTH-1] ? '0 : win_max;
`else
    assign win_out  = win_max;
`endif

    // Line buffer holds the even-row pair maxima; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (accept && col_q[0] && !row_q[0]) linebuf[lb_idx] <= pair_max;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q          <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pixel_out_q  <= '0;
        end else begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (accept) begin
                if (!col_q[0]) begin
                    h_q <= px;
                end else if (row_q[0]) begin
                    out_valid_q  <= 1'b1;
                    frame_done_q <= last_beat;
                    pixel_out_q  <= win_out;
                end
            end
        end
    end

    assign busy           = (state_q == ACTIVE);
    assign pix.out_valid  = out_valid_q;
    assign pix.frame_done = frame_done_q;
    assign pix.pixel_out  = pixel_out_q;

endmodule
